line_sensor_filter: RTL and testbench

//  Conditions the three raw reflectance-sensor inputs before the line-following controller uses them.

---
 rtl/line_follow_pkg.sv | 21 ++
 rtl/sensor_debounce_ch.sv | 63 ++++++
 rtl/line_sensor_filter.sv | 87 ++++++++
 tb/tb_line_sensor_filter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared definitions for the line-following datapath: sensor bit order and
// named sensor patterns as seen by the controller.
package line_follow_pkg;

  typedef logic [2:0] sens_vec_t;

  // Bit positions within a {L,M,R} sensor vector
  localparam int SENS_L = 2;
  localparam int SENS_M = 1;
  localparam int SENS_R = 0;

  // 1 = no line, 0 = line under the sensor
  localparam sens_vec_t PAT_CENTRE = 3'b101;
  localparam sens_vec_t PAT_LOST   = 3'b111;
  localparam sens_vec_t PAT_T      = 3'b000;

  function automatic sens_vec_t pack_sensors(input logic l, input logic m, input logic r);
    return {l, m, r};
  endfunction

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: 2-flop synchroniser, saturating tick-driven integrator
// and hysteresis comparator producing the filtered bit.
module sensor_debounce_ch #(
  parameter int ACC_MAX = 15,
  parameter int TH_HI   = 12,
  parameter int TH_LO   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic filt,
  output logic changed
);

  localparam int ACC_W = $clog2(ACC_MAX + 1);
  localparam logic [ACC_W-1:0] ACC_TOP = ACC_W'(ACC_MAX);
  localparam logic [ACC_W-1:0] HI_V    = ACC_W'(TH_HI);
  localparam logic [ACC_W-1:0] LO_V    = ACC_W'(TH_LO);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             filt_reg;
  logic             filt_next;

  always_comb begin
    acc_next  = acc_reg;
    filt_next = filt_reg;
    if (tick) begin
      if (sync2_reg && (acc_reg != ACC_TOP)) begin
        acc_next = acc_reg + 1'b1;
      end else if (!sync2_reg && (acc_reg != '0)) begin
        acc_next = acc_reg - 1'b1;
      end
      // Thresholds are applied to the value being written this edge
      if (acc_next >= HI_V) begin
        filt_next = 1'b1;
      end else if (acc_next <= LO_V) begin
        filt_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      acc_reg   <= ACC_TOP;
      filt_reg  <= 1'b1;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      acc_reg   <= acc_next;
      filt_reg  <= filt_next;
    end
  end

  assign filt    = filt_reg;
  assign changed = filt_next != filt_reg;

endmodule

// File: rtl/line_sensor_filter.sv
// Three-channel reflectance sensor conditioner: shared sample prescaler,
// per-channel debounce, change pulse and sticky settle (ready) flag.
module line_sensor_filter
  import line_follow_pkg::*;
#(
  parameter int SAMPLE_DIV  = 50000,
  parameter int ACC_MAX     = 15,
  parameter int TH_HI       = 12,
  parameter int TH_LO       = 3,
  parameter int READY_TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensorLeftRaw,
  input  logic sensorMiddleRaw,
  input  logic sensorRightRaw,
  output logic sensorLeftFiltered,
  output logic sensorMiddleFiltered,
  output logic sensorRightFiltered,
  output logic sensors_changed,
  output logic sensors_ready
);

  localparam int PRESC_W = $clog2(SAMPLE_DIV);
  localparam int RDY_W   = $clog2(READY_TICKS + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
  localparam logic [RDY_W-1:0]   RDY_LAST   = RDY_W'(READY_TICKS);

  logic [PRESC_W-1:0] presc_reg;
  logic [RDY_W-1:0]   ready_cnt_reg;
  logic [RDY_W-1:0]   ready_cnt_next;
  logic               ready_reg;
  logic               changed_reg;
  logic               tick;
  sens_vec_t          raw_vec;
  sens_vec_t          filt_vec;
  sens_vec_t          ch_changed;

  assign tick    = presc_reg == PRESC_LAST;
  assign raw_vec = pack_sensors(sensorLeftRaw, sensorMiddleRaw, sensorRightRaw);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      sensor_debounce_ch #(
        .ACC_MAX (ACC_MAX),
        .TH_HI   (TH_HI),
        .TH_LO   (TH_LO)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (raw_vec[gi]),
        .tick    (tick),
        .filt    (filt_vec[gi]),
        .changed (ch_changed[gi])
      );
    end
  endgenerate

  always_comb begin
    ready_cnt_next = ready_cnt_reg;
    if (tick && (ready_cnt_reg != RDY_LAST)) begin
      ready_cnt_next = ready_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      ready_cnt_reg <= '0;
      ready_reg     <= 1'b0;
      changed_reg   <= 1'b0;
    end else begin
      presc_reg     <= tick ? '0 : presc_reg + 1'b1;
      ready_cnt_reg <= ready_cnt_next;
      // Sticky: rises on the edge of the READY_TICKS-th tick
      ready_reg     <= ready_reg | (ready_cnt_next == RDY_LAST);
      changed_reg   <= |ch_changed;
    end
  end

  assign sensorLeftFiltered   = filt_vec[SENS_L];
  assign sensorMiddleFiltered = filt_vec[SENS_M];
  assign sensorRightFiltered  = filt_vec[SENS_R];
  assign sensors_changed      = changed_reg;
  assign sensors_ready        = ready_reg;

endmodule

// File: tb/tb_line_sensor_filter.sv
// Directed bench for line_sensor_filter with SAMPLE_DIV=4, ACC_MAX=7,
// TH_HI=6, TH_LO=1, READY_TICKS=8; ticks land on edges 4,8,12,... after release.
module tb_line_sensor_filter;
  import line_follow_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic l_raw, m_raw, r_raw;
  logic l_filt, m_filt, r_filt;
  logic changed, ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  line_sensor_filter #(
    .SAMPLE_DIV  (4),
    .ACC_MAX     (7),
    .TH_HI       (6),
    .TH_LO       (1),
    .READY_TICKS (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sensorLeftRaw        (l_raw),
    .sensorMiddleRaw      (m_raw),
    .sensorRightRaw       (r_raw),
    .sensorLeftFiltered   (l_filt),
    .sensorMiddleFiltered (m_filt),
    .sensorRightFiltered  (r_filt),
    .sensors_changed      (changed),
    .sensors_ready        (ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge; cyc counts edges since the last reset release
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Advance to edge 'target' checking a steady filtered pattern with no change pulse
  task automatic run_to(input int target, input sens_vec_t exp);
    while (cyc < target) begin
      step();
      check_eq("steady_filt", {l_filt, m_filt, r_filt}, exp);
      check_eq("no_pulse", changed, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    l_raw = 1'b1; m_raw = 1'b1; r_raw = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_filt", {l_filt, m_filt, r_filt}, PAT_LOST);
    check_eq("rst_changed", changed, 1'b0);
    check_eq("rst_ready", ready, 1'b0);
    $display("T1 reset: filt=%b changed=%b ready=%b", {l_filt, m_filt, r_filt}, changed, ready);

    rst_n = 1'b1;
    cyc = 0;
    run_to(31, PAT_LOST);
    check_eq("ready_before_8th_tick", ready, 1'b0);
    step();
    check_eq("ready_at_8th_tick", ready, 1'b1);
    $display("T1 ready rose at cycle %0d", cyc);

    m_raw = 1'b0;
    run_to(55, PAT_LOST);
    step();
    check_eq("mid_fall_filt", {l_filt, m_filt, r_filt}, PAT_CENTRE);
    check_eq("mid_fall_pulse", changed, 1'b1);
    step();
    check_eq("mid_pulse_len", changed, 1'b0);
    $display("T2 middle fell at cycle 56: filt=%b", {l_filt, m_filt, r_filt});

    l_raw = 1'b0;
    run_to(61, PAT_CENTRE);
    l_raw = 1'b1;
    run_to(65, PAT_CENTRE);
    $display("T3 left short low: filt=%b", {l_filt, m_filt, r_filt});

    r_raw = 1'b0;
    run_to(81, PAT_CENTRE);
    for (int i = 0; i < 6; i++) begin
      r_raw = (i % 2 == 0);
      run_to(85 + 4 * i, PAT_CENTRE);
    end
    r_raw = 1'b1;
    run_to(121, PAT_CENTRE);
    $display("T4 right mid-band alternation: filt=%b", {l_filt, m_filt, r_filt});

    l_raw = 1'b0;
    r_raw = 1'b0;
    run_to(143, PAT_CENTRE);
    step();
    check_eq("lr_fall_filt", {l_filt, m_filt, r_filt}, PAT_T);
    check_eq("lr_fall_pulse", changed, 1'b1);
    step();
    check_eq("lr_single_pulse", changed, 1'b0);
    $display("T5 left+right fell at cycle 144: filt=%b", {l_filt, m_filt, r_filt});

    m_raw = 1'b1;
    run_to(161, PAT_T);
    check_eq("ready_sticky", ready, 1'b1);
    rst_n = 1'b0;
    step();
    check_eq("midrst_filt", {l_filt, m_filt, r_filt}, PAT_LOST);
    check_eq("midrst_changed", changed, 1'b0);
    check_eq("midrst_ready", ready, 1'b0);
    rst_n = 1'b1;
    l_raw = 1'b1; m_raw = 1'b0; r_raw = 1'b1;
    cyc = 0;
    run_to(23, PAT_LOST);
    step();
    check_eq("post_rst_mid_fall", {l_filt, m_filt, r_filt}, PAT_CENTRE);
    check_eq("post_rst_pulse", changed, 1'b1);
    run_to(31, PAT_CENTRE);
    check_eq("post_rst_ready_low", ready, 1'b0);
    step();
    check_eq("post_rst_ready_high", ready, 1'b1);
    $display("T6 mid-op reset: middle fell at rel cycle 24, ready at rel cycle %0d", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
